cache_data_array_rw: RTL and testbench

//  Parametrised single-port, byte-masked cache data array with a valid/ready request

---
 rtl/cache_data_array_rw.sv | 186 ++++++++++++++++++
 tb/tb_cache_data_array_rw.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_data_array_rw.sv
// Single-port, byte-masked cache data array with a valid/ready request port, 1- or 2-cycle
// registered read latency and a zeroing init sweep after reset. Define CACHE_DATA_ARRAY_PARITY_EN for per-byte parity.
module cache_data_array_rw #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 5,
    parameter int READ_LAT   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH/8-1:0] req_wmask,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_perr,
    output logic                    init_done
);
    localparam int NUM_WMASKS = DATA_WIDTH / 8;
    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [NUM_WMASKS-1:0] mask
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_w;
        for (int b = 0; b < NUM_WMASKS; b++) begin
            if (mask[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
    logic                    sweep_we;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    logic                    wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    rd_perr;

    logic                    rsp_vld_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_d;
    logic                    rsp_perr_d;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_perr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The extra counter bit turns the INIT exit into a single-bit decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_d[ADDR_WIDTH]) state_d = ST_RUN;
        end
    end

    always_comb begin
        req_ready = 1'b0;
        init_done = 1'b0;
        sweep_we  = 1'b0;
        if (state_q == ST_RUN) begin
            req_ready = 1'b1;
            init_done = 1'b1;
        end else begin
            sweep_we  = 1'b1;
        end
    end

    assign wr_acc  = req_valid && req_ready && req_we;
    assign rd_acc  = req_valid && req_ready && !req_we;
    assign rd_word = mem_q[req_addr];

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = req_addr;
        mem_wdata = merge_bytes(rd_word, req_wdata, req_wmask);
        if (sweep_we) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q[ADDR_WIDTH-1:0];
            mem_wdata = '0;
        end else if (wr_acc) begin
            mem_we    = 1'b1;
        end
    end

    // Storage has no reset; writes are held off while rst is asserted.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem_q[mem_waddr] <= mem_wdata;
    end

`ifdef CACHE_DATA_ARRAY_PARITY_EN
    function automatic logic [NUM_WMASKS-1:0] byte_parity(input logic [DATA_WIDTH-1:0] w);
        logic [NUM_WMASKS-1:0] p;
        for (int b = 0; b < NUM_WMASKS; b++) p[b] = ^w[8*b +: 8];
        return p;
    endfunction

    logic [NUM_WMASKS-1:0] parity_q [DEPTH];
    logic [NUM_WMASKS-1:0] par_wdata;

    always_comb begin
        par_wdata = (parity_q[req_addr] & ~req_wmask) | (byte_parity(req_wdata) & req_wmask);
        if (sweep_we) par_wdata = '0;
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) parity_q[mem_waddr] <= par_wdata;
    end

    assign rd_perr = |(byte_parity(rd_word) ^ parity_q[req_addr]);
`else
    assign rd_perr = 1'b0;
`endif

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic                  vld_p1_q;
            logic [DATA_WIDTH-1:0] rdata_p1_q;
            logic                  perr_p1_q;

            // Stage p1: the word is captured at the acceptance edge, so a later write cannot leak in.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) vld_p1_q <= 1'b0;
                else     vld_p1_q <= rd_acc;
            end

            always_ff @(posedge clk) begin
                if (rd_acc) begin
                    rdata_p1_q <= rd_word;
                    perr_p1_q  <= rd_perr;
                end
            end

            assign rsp_vld_d   = vld_p1_q;
            assign rsp_rdata_d = rdata_p1_q;
            assign rsp_perr_d  = perr_p1_q;
        end else begin : g_lat1
            assign rsp_vld_d   = rd_acc;
            assign rsp_rdata_d = rd_word;
            assign rsp_perr_d  = rd_perr;
        end
    endgenerate

    // Response stage: data and error flag hold until the next response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_perr_q  <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_vld_d;
            if (rsp_vld_d) begin
                rsp_rdata_q <= rsp_rdata_d;
                rsp_perr_q  <= rsp_perr_d;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_perr  = rsp_perr_q;

endmodule

// File: tb/tb_cache_data_array_rw.sv
// Directed bench for cache_data_array_rw: one READ_LAT=1 and one READ_LAT=2 instance share the request inputs.
`timescale 1ns/1ps
module tb_cache_data_array_rw;
    localparam int DW = 256;
    localparam int AW = 5;
    localparam int NM = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_we;
    logic [AW-1:0] req_addr;
    logic [NM-1:0] req_wmask;
    logic [DW-1:0] req_wdata;
    logic          rdy1, vld1, perr1, done1;
    logic          rdy2, vld2, perr2, done2;
    logic [DW-1:0] rd1, rd2;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] exp_mem [32];

    always #5 clk = ~clk;

    cache_data_array_rw #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LAT(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
        .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
        .rsp_valid(vld1), .rsp_rdata(rd1), .rsp_perr(perr1), .init_done(done1));

    cache_data_array_rw #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy2), .req_we(req_we),
        .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
        .rsp_valid(vld2), .rsp_rdata(rd2), .rsp_perr(perr2), .init_done(done2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wmask = '0; req_wdata = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NM-1:0] m);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
        tick();
        idle();
        for (int b = 0; b < NM; b++) if (m[b]) exp_mem[a][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic rd_req(input logic [AW-1:0] a);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wmask = '0; req_wdata = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({rdy1, vld1, perr1, done1, rdy2, vld2, perr2, done2} !== 8'h00 || rd1 !== '0 || rd2 !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy/vld/perr/done=%b%b%b%b %b%b%b%b rd1=%h, want all 0",
                     rdy1, vld1, perr1, done1, rdy2, vld2, perr2, done2, rd1);
        end
        rst = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            tick();
            if (c == 31) begin
                n_cmp++;
                if ({done1, rdy1, done2, rdy2} !== 4'b0000) begin
                    n_err++;
                    $display("FAIL init_edge31: got done/ready=%b%b %b%b, want 0000", done1, rdy1, done2, rdy2);
                end
            end
            if (c == 32) begin
                n_cmp++;
                if ({done1, rdy1, done2, rdy2} !== 4'b1111) begin
                    n_err++;
                    $display("FAIL init_edge32: got done/ready=%b%b %b%b, want 1111", done1, rdy1, done2, rdy2);
                end
            end
        end
        for (int a = 0; a < 32; a++) exp_mem[a] = '0;
    endtask

    task automatic test_stream(input string tag);
        int pulses2;
        pulses2 = 0;
        for (int a = 0; a <= 32; a++) begin
            if (a < 32) rd_req(AW'(a));
            else        idle();
            tick();
            if (a < 32) begin
                n_cmp++;
                if (vld1 !== 1'b1 || rd1 !== exp_mem[a]) begin
                    n_err++;
                    $display("FAIL %s_lat1_addr%0d: got vld=%b data=%h, want vld=1 data=%h", tag, a, vld1, rd1, exp_mem[a]);
                end
            end else begin
                n_cmp++;
                if (vld1 !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s_lat1_pulse_end: got vld=%b, want 0", tag, vld1);
                end
            end
            if (a == 0) begin
                n_cmp++;
                if (vld2 !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s_lat2_early: got vld=%b, want 0", tag, vld2);
                end
            end else begin
                n_cmp++;
                if (vld2 !== 1'b1 || rd2 !== exp_mem[a-1]) begin
                    n_err++;
                    $display("FAIL %s_lat2_addr%0d: got vld=%b data=%h, want vld=1 data=%h", tag, a-1, vld2, rd2, exp_mem[a-1]);
                end
            end
            if (vld2 === 1'b1) pulses2++;
        end
        tick();
        n_cmp++;
        if (vld1 !== 1'b0 || vld2 !== 1'b0 || pulses2 !== 32) begin
            n_err++;
            $display("FAIL %s_stream_end: got vld1=%b vld2=%b pulses=%0d, want 0 0 32", tag, vld1, vld2, pulses2);
        end
    endtask

    task automatic test_masked_write();
        logic [DW-1:0] expw;
        expw = {{28{8'hAA}}, {4{8'h55}}};
        wr(5'd3, {32{8'hAA}}, 32'hFFFF_FFFF);
        wr(5'd3, {32{8'h55}}, 32'h0000_000F);
        rd_req(5'd3);
        tick();
        idle();
        n_cmp++;
        if (vld1 !== 1'b1 || rd1 !== expw || perr1 !== 1'b0 || vld2 !== 1'b0) begin
            n_err++;
            $display("FAIL masked_lat1: got vld1=%b vld2=%b perr=%b data=%h, want 1 0 0 %h", vld1, vld2, perr1, rd1, expw);
        end
        tick();
        n_cmp++;
        if (vld1 !== 1'b0 || vld2 !== 1'b1 || rd2 !== expw || rd1 !== expw) begin
            n_err++;
            $display("FAIL masked_lat2: got vld1=%b vld2=%b data=%h held=%h, want 0 1 %h", vld1, vld2, rd2, rd1, expw);
        end
        wr(5'd3, '0, '0);
        rd_req(5'd3);
        tick();
        idle();
        n_cmp++;
        if (vld1 !== 1'b1 || rd1 !== expw) begin
            n_err++;
            $display("FAIL mask0_noop: got vld=%b data=%h, want 1 %h", vld1, rd1, expw);
        end
        tick();
        n_cmp++;
        if (vld1 !== 1'b0 || vld2 !== 1'b1 || rd2 !== expw) begin
            n_err++;
            $display("FAIL mask0_noop_lat2: got vld1=%b vld2=%b data=%h, want 0 1 %h", vld1, vld2, rd2, expw);
        end
        tick();
    endtask

    task automatic test_hazards();
        logic [DW-1:0] y, z;
        y = {8{32'hDEAD_BEEF}};
        z = {8{32'h0123_4567}};
        wr(5'd7, {32{8'h3C}}, 32'hFFFF_FFFF);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd7; req_wdata = y; req_wmask = 32'hFFFF_FFFF;
        tick();
        rd_req(5'd7);
        tick();
        idle();
        n_cmp++;
        if (vld1 !== 1'b1 || rd1 !== y) begin
            n_err++;
            $display("FAIL raw_lat1: got vld=%b data=%h, want 1 %h", vld1, rd1, y);
        end
        tick();
        n_cmp++;
        if (vld2 !== 1'b1 || rd2 !== y) begin
            n_err++;
            $display("FAIL raw_lat2: got vld=%b data=%h, want 1 %h", vld2, rd2, y);
        end
        rd_req(5'd7);
        tick();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd7; req_wdata = z; req_wmask = 32'hFFFF_FFFF;
        n_cmp++;
        if (vld1 !== 1'b1 || rd1 !== y) begin
            n_err++;
            $display("FAIL war_lat1: got vld=%b data=%h, want 1 %h", vld1, rd1, y);
        end
        tick();
        idle();
        n_cmp++;
        if (vld2 !== 1'b1 || rd2 !== y || vld1 !== 1'b0) begin
            n_err++;
            $display("FAIL war_lat2: got vld2=%b data=%h vld1=%b, want 1 %h 0", vld2, rd2, vld1, y);
        end
        rd_req(5'd7);
        tick();
        idle();
        tick();
        n_cmp++;
        if (rd1 !== z || vld2 !== 1'b1 || rd2 !== z) begin
            n_err++;
            $display("FAIL war_after: got rd1=%h rd2=%h vld2=%b, want %h", rd1, rd2, vld2, z);
        end
        exp_mem[7] = z;
        tick();
    endtask

    task automatic test_fill();
        logic [7:0] bv;
        for (int a = 0; a < 32; a++) begin
            bv = 8'(a * 37 + 1);
            wr(AW'(a), {32{bv}}, 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        rd_req(5'd7);
        tick();
        idle();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({vld1, vld2, rdy1, rdy2, done1, done2} !== 6'b000000 || rd1 !== '0 || rd2 !== '0) begin
            n_err++;
            $display("FAIL rst_async: got vld=%b%b rdy=%b%b done=%b%b, want all 0", vld1, vld2, rdy1, rdy2, done1, done2);
        end
        tick(); tick();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (vld1 !== 1'b0 || vld2 !== 1'b0 || rdy1 !== 1'b0 || rdy2 !== 1'b0) bad++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            tick();
            if (vld1 !== 1'b0 || vld2 !== 1'b0) bad++;
            if (c < 32 && (rdy1 !== 1'b0 || rdy2 !== 1'b0)) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL rst_sweep_quiet: got %0d bad cycles, want 0", bad);
        end
        n_cmp++;
        if (rdy1 !== 1'b1 || rdy2 !== 1'b1 || done1 !== 1'b1) begin
            n_err++;
            $display("FAIL rst_sweep_done: got rdy=%b%b done=%b, want 111", rdy1, rdy2, done1);
        end
        for (int a = 0; a < 32; a++) exp_mem[a] = '0;
        rd_req(5'd7);
        tick();
        rd_req(5'd3);
        tick();
        idle();
        n_cmp++;
        if (vld1 !== 1'b1 || rd1 !== '0 || vld2 !== 1'b1 || rd2 !== '0) begin
            n_err++;
            $display("FAIL rst_cleared: got vld=%b%b rd1=%h rd2=%h, want 11 and 0", vld1, vld2, rd1, rd2);
        end
        tick();
    endtask

`ifdef CACHE_DATA_ARRAY_PARITY_EN
    task automatic test_parity();
        wr(5'd5, {32{8'h6B}}, 32'hFFFF_FFFF);
        wr(5'd6, {32{8'h6B}}, 32'hFFFF_FFFF);
        dut.parity_q[5][2] = ~dut.parity_q[5][2];
        rd_req(5'd5);
        tick();
        idle();
        n_cmp++;
        if (vld1 !== 1'b1 || perr1 !== 1'b1 || rd1 !== {32{8'h6B}}) begin
            n_err++;
            $display("FAIL parity_flip: got vld=%b perr=%b data=%h, want 1 1 %h", vld1, perr1, rd1, {32{8'h6B}});
        end
        tick();
        rd_req(5'd6);
        tick();
        idle();
        n_cmp++;
        if (vld1 !== 1'b1 || perr1 !== 1'b0) begin
            n_err++;
            $display("FAIL parity_clean: got vld=%b perr=%b, want 1 0", vld1, perr1);
        end
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_stream("zero");
        test_masked_write();
        test_hazards();
        test_fill();
        test_stream("fill");
`ifdef CACHE_DATA_ARRAY_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
